mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_arb_pkg.sv | 42 ++++
 rtl/mux4_sel.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and defaults for the four-requester round-robin mux arbiter.
package mux4_arb_pkg;

    // Default data width of each requester input and of the muxed output.
    localparam int DEFAULT_WIDTH     = 8;

    // Default number of back-to-back grant cycles an owner may hold while others wait.
    localparam int DEFAULT_MAX_BURST = 4;

    // Two-bit requester index, also used for the mux select and the rotation pointer.
    typedef logic [1:0] idx_t;

    // Arbiter states: nobody owns the mux, or exactly one requester does.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns the first requester with its req bit set, scanning ptr, ptr+1, ... mod 4.
    // When no bit is set the result is ptr; callers only use it when |req is true.
    function automatic idx_t rrPick(input logic [3:0] req, input idx_t ptr);
        idx_t cand;
        idx_t pick;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + idx_t'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Converts a requester index into its one-hot grant vector.
    function automatic logic [3:0] oneHot(input idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_sel.sv
// 4:1 data select built as a tree of three 2:1 stages; s0 picks within a pair, s1 picks the pair.
module mux4_sel
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] w_low;
    logic [WIDTH-1:0] w_high;

    // First rank: choose within the low pair (i0/i1) and the high pair (i2/i3).
    always_comb begin
        w_low  = s0 ? i1 : i0;
        w_high = s0 ? i3 : i2;
    end

    // Second rank: choose between the two pair results.
    always_comb begin
        y = s1 ? w_high : w_low;
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that hands a shared 4:1 data mux to one of four requesters,
// limiting an owner to MAX_BURST consecutive cycles whenever someone else is waiting.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             valid,
    output logic [WIDTH-1:0] y
);

    // Counter value on which the owner's burst is complete.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     r_state;
    logic [3:0] r_gnt;
    idx_t       r_sel;
    idx_t       r_ptr;
    logic [3:0] r_cnt;

    state_t     w_nextState;
    logic [3:0] w_nextGnt;
    idx_t       w_nextSel;
    idx_t       w_nextPtr;
    logic [3:0] w_nextCnt;

    idx_t       w_relPtr;
    idx_t       w_pickIdle;
    idx_t       w_pickRel;
    logic       w_ownerReq;
    logic       w_othersReq;
    logic       w_atLast;
    logic       w_release;

    // While granted, r_sel always names the owner, so it doubles as the owner index.
    // The release search starts just past the owner, which leaves the owner's own req last.
    always_comb begin
        w_relPtr    = r_sel + 2'd1;
        w_pickIdle  = rrPick(req, r_ptr);
        w_pickRel   = rrPick(req, w_relPtr);
        w_ownerReq  = req[r_sel];
        w_othersReq = |(req & ~oneHot(r_sel));
        w_atLast    = (r_cnt == BURST_LAST);
        w_release   = !w_ownerReq || (w_atLast && w_othersReq);
    end

    // Next-state logic: start a grant from IDLE, or extend, wrap or hand off the current burst.
    always_comb begin
        w_nextState = r_state;
        w_nextGnt   = r_gnt;
        w_nextSel   = r_sel;
        w_nextPtr   = r_ptr;
        w_nextCnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_nextState = GRANT;
                    w_nextGnt   = oneHot(w_pickIdle);
                    w_nextSel   = w_pickIdle;
                    w_nextCnt   = 4'd0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_nextPtr = w_relPtr;
                    w_nextCnt = 4'd0;
                    if (|req) begin
                        w_nextGnt = oneHot(w_pickRel);
                        w_nextSel = w_pickRel;
                    end else begin
                        w_nextState = IDLE;
                        w_nextGnt   = 4'b0000;
                    end
                end else if (w_atLast) begin
                    w_nextCnt = 4'd0;
                end else begin
                    w_nextCnt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextGnt   = 4'b0000;
            end
        endcase
    end

    // State register with synchronous reset that wins over any request activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_gnt   <= w_nextGnt;
            r_sel   <= w_nextSel;
            r_ptr   <= w_nextPtr;
            r_cnt   <= w_nextCnt;
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = |r_gnt;

    mux4_sel #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i0 (d0),
        .i1 (d1),
        .i2 (d2),
        .i3 (d3),
        .s0 (r_sel[0]),
        .s1 (r_sel[1]),
        .y  (y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for the round-robin mux arbiter: default-burst instance plus a MAX_BURST=1 instance.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] y;

    logic       rst1;
    logic [3:0] req1;
    logic [3:0] gnt1;
    logic [1:0] sel1;
    logic       valid1;
    logic [7:0] y1;

    logic [7:0] dVals [4];

    int nChecks;
    int nFails;

    mux4_rr_arbiter #(
        .WIDTH     (8),
        .MAX_BURST (4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    mux4_rr_arbiter #(
        .WIDTH     (8),
        .MAX_BURST (1)
    ) u_dut1 (
        .clk   (clk),
        .rst   (rst1),
        .req   (req1),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .gnt   (gnt1),
        .sel   (sel1),
        .valid (valid1),
        .y     (y1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    // Reset overrides requests, then an idle period keeps everything low with y following d0.
    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        nChecks++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_override: gnt=%b sel=%b valid=%b, required 0000/00/0", gnt, sel, valid);
        end
        rst = 1'b0;
        req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            nChecks++;
            if (gnt !== 4'b0000 || sel !== 2'b00 || valid !== 1'b0 || y !== 8'hA5) begin
                nFails++;
                $display("[TB] FAIL idle_cycle%0d: gnt=%b sel=%b valid=%b y=%h, required 0000/00/0/a5",
                         c, gnt, sel, valid, y);
            end
        end
    endtask

    // All four request continuously: each owner gets exactly 4 cycles in rotation order.
    task automatic test_rotation();
        int         owner;
        logic [3:0] expGnt;
        doReset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            owner  = (c / 4) % 4;
            expGnt = 4'b0001 << owner;
            nChecks++;
            if (gnt !== expGnt || sel !== 2'(owner) || valid !== 1'b1 || y !== dVals[owner]) begin
                nFails++;
                $display("[TB] FAIL rotation_cycle%0d: gnt=%b sel=%b valid=%b y=%h, required %b/%0d/1/%h",
                         c, gnt, sel, valid, y, expGnt, owner, dVals[owner]);
            end
        end
    endtask

    // A lone requester keeps the grant through counter wraps.
    task automatic test_single_hold();
        doReset();
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick();
            nChecks++;
            if (gnt !== 4'b0100 || sel !== 2'd2 || valid !== 1'b1 || y !== 8'hC3) begin
                nFails++;
                $display("[TB] FAIL single_hold_cycle%0d: gnt=%b sel=%b valid=%b y=%h, required 0100/10/1/c3",
                         c, gnt, sel, valid, y);
            end
        end
    endtask

    // Owner 1 drops its request: the search from ptr=2 lands on 3 with no idle bubble,
    // then releasing with nothing pending goes idle while sel holds.
    task automatic test_owner_drop();
        doReset();
        req = 4'b0010;
        tick();
        nChecks++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            nFails++;
            $display("[TB] FAIL drop_first_grant: gnt=%b sel=%b, required 0010/01", gnt, sel);
        end
        tick();
        req = 4'b1001;
        tick();
        nChecks++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || valid !== 1'b1 || y !== 8'h5A) begin
            nFails++;
            $display("[TB] FAIL drop_handoff: gnt=%b sel=%b valid=%b y=%h, required 1000/11/1/5a",
                     gnt, sel, valid, y);
        end
        req = 4'b0000;
        tick();
        nChecks++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || sel !== 2'd3 || y !== 8'h5A) begin
            nFails++;
            $display("[TB] FAIL release_to_idle: gnt=%b valid=%b sel=%b y=%h, required 0000/0/11/5a",
                     gnt, valid, sel, y);
        end
    endtask

    // Reset during requester 2's second burst cycle drops the grant; restart begins at requester 0.
    task automatic test_reset_mid_burst();
        doReset();
        req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        nChecks++;
        if (gnt !== 4'b0100) begin
            nFails++;
            $display("[TB] FAIL midburst_owner: gnt=%b, required 0100", gnt);
        end
        rst = 1'b1;
        tick();
        nChecks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midburst_reset: gnt=%b sel=%b valid=%b, required 0000/00/0", gnt, sel, valid);
        end
        rst = 1'b0;
        tick();
        nChecks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            nFails++;
            $display("[TB] FAIL midburst_restart: gnt=%b sel=%b, required 0001/00", gnt, sel);
        end
    endtask

    // With MAX_BURST=1 two contenders alternate every cycle; a lone requester still holds.
    task automatic test_max_burst_one();
        logic [3:0] expGnt;
        rst1 = 1'b1;
        req1 = 4'b0000;
        tick();
        rst1 = 1'b0;
        req1 = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            tick();
            expGnt = (c % 2 == 0) ? 4'b0001 : 4'b0010;
            nChecks++;
            if (gnt1 !== expGnt || valid1 !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL burst1_alt_cycle%0d: gnt=%b valid=%b, required %b/1", c, gnt1, valid1, expGnt);
            end
        end
        req1 = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            nChecks++;
            if (gnt1 !== 4'b0001) begin
                nFails++;
                $display("[TB] FAIL burst1_alone_cycle%0d: gnt=%b, required 0001", c, gnt1);
            end
        end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        nChecks  = 0;
        nFails   = 0;
        rst      = 1'b1;
        rst1     = 1'b1;
        req      = 4'b0000;
        req1     = 4'b0000;
        d0       = 8'hA5;
        d1       = 8'h3C;
        d2       = 8'hC3;
        d3       = 8'h5A;
        dVals[0] = 8'hA5;
        dVals[1] = 8'h3C;
        dVals[2] = 8'hC3;
        dVals[3] = 8'h5A;
        #2;
        test_reset();
        test_rotation();
        test_single_hold();
        test_owner_drop();
        test_reset_mid_burst();
        test_max_burst_one();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
